// File: rtl/rx_tlp_trigger_pkg.sv
// Shared definitions for the RX TLP trigger.
// Holds the default geometry of the qword ring and the huge page,
// the flush timeout, the field widths of the page fill counter and
// the qword count, and the encoding of the request state machine.
package rx_tlp_trigger_pkg;

  // Log2 of the RAM depth minus one; ring addresses are BF+1 bits wide.
  localparam int BF          = 8;
  localparam int ADDR_W_DEF  = BF + 1;
  localparam int MAX_QW_DEF  = 16;       // 128-byte max payload
  localparam int PAGE_QW_DEF = 262144;   // 2 MB huge page in qwords
  localparam int TIMEOUT_DEF = 1024;     // idle cycles before a partial flush

  localparam int PAGE_USED_W = 19;       // holds 0..PAGE_QW inclusive
  localparam int QW_W        = 5;        // holds 1..16

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TLP  = 2'd1,
    ST_WAIT_PAGE = 2'd2
  } state_e;

endpackage

// File: rtl/rx_tlp_trigger.sv
// RX TLP trigger: decides when the PCIe write engine emits a memory-write
// TLP, how many qwords it carries, and when to switch to a new huge page.
//
// Ports:
//   trn_clk                        clock
//   reset                          synchronous, active-high reset
//   commited_wr_address            ring address one past the last committed qword
//   trigger_tlp                    TLP request (level, held until ack)
//   trigger_tlp_ack                one-cycle acknowledge of trigger_tlp
//   qwords_to_send                 payload qwords of the pending request
//   change_huge_page               page-switch request (level, held until ack)
//   change_huge_page_ack           one-cycle acknowledge of change_huge_page
//   send_last_tlp_change_huge_page a final TLP of qwords_to_send precedes the switch
//   issued_rd_address              ring address one past the last qword handed out
module rx_tlp_trigger
  import rx_tlp_trigger_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_QW  = MAX_QW_DEF,
  parameter int PAGE_QW = PAGE_QW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              trn_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] commited_wr_address,
  output logic              trigger_tlp,
  input  logic              trigger_tlp_ack,
  output logic [QW_W-1:0]   qwords_to_send,
  output logic              change_huge_page,
  input  logic              change_huge_page_ack,
  output logic              send_last_tlp_change_huge_page,
  output logic [ADDR_W-1:0] issued_rd_address
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int ROOM_W = PAGE_USED_W + 1;

  localparam logic [ADDR_W-1:0] MAX_QW_A  = ADDR_W'(MAX_QW);
  localparam logic [QW_W-1:0]   MAX_QW_Q  = QW_W'(MAX_QW);
  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);
  localparam logic [ROOM_W-1:0] PAGE_QW_C = ROOM_W'(PAGE_QW);

  state_e                 state_q, state_d;
  logic                   trig_q, trig_d;
  logic                   chg_q, chg_d;
  logic                   last_q, last_d;
  logic [QW_W-1:0]        qw_q, qw_d;
  logic [ADDR_W-1:0]      rd_q, rd_d;
  logic [ADDR_W-1:0]      wr_prev_q;
  logic [PAGE_USED_W-1:0] used_q, used_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;

  logic [ADDR_W-1:0]      avail;
  logic [QW_W-1:0]        n_qw;
  logic [ROOM_W-1:0]      room;
  logic                   ack_any;
  logic                   flush;

  function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
    return (v == TIMEOUT_C) ? v : v + IDLE_W'(1);
  endfunction

  // Unsigned modular difference stays correct across ring wrap.
  assign avail   = commited_wr_address - rd_q;
  assign n_qw    = (avail >= MAX_QW_A) ? MAX_QW_Q : avail[QW_W-1:0];
  assign room    = PAGE_QW_C - {1'b0, used_q};
  assign ack_any = trigger_tlp_ack | change_huge_page_ack;
  // A full payload goes out at once; a partial one only after sitting idle.
  assign flush   = (avail >= MAX_QW_A) || ((avail != '0) && (idle_q == TIMEOUT_C));

  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    chg_d   = chg_q;
    last_d  = last_q;
    qw_d    = qw_q;
    rd_d    = rd_q;
    used_d  = used_q;
    // Idle time restarts on any commit activity, an empty ring or an ack.
    if ((commited_wr_address != wr_prev_q) || (avail == '0) || ack_any) begin
      idle_d = '0;
    end else begin
      idle_d = sat_inc(idle_q);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (room == '0) begin
          // Page exactly full: switch with nothing left to send in it.
          chg_d   = 1'b1;
          last_d  = 1'b0;
          state_d = ST_WAIT_PAGE;
        end else if (flush) begin
          if (ROOM_W'(n_qw) <= room) begin
            trig_d  = 1'b1;
            qw_d    = n_qw;
            state_d = ST_WAIT_TLP;
          end else begin
            // Payload straddles the page end: send what fits, then switch.
            // room < n_qw <= MAX_QW here, so it fits in qwords_to_send.
            chg_d   = 1'b1;
            last_d  = 1'b1;
            qw_d    = room[QW_W-1:0];
            state_d = ST_WAIT_PAGE;
          end
        end
      end
      ST_WAIT_TLP: begin
        if (trigger_tlp_ack) begin
          trig_d  = 1'b0;
          rd_d    = rd_q + ADDR_W'(qw_q);
          used_d  = used_q + PAGE_USED_W'(qw_q);
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_PAGE: begin
        if (change_huge_page_ack) begin
          chg_d  = 1'b0;
          last_d = 1'b0;
          used_d = '0;
          if (last_q) begin
            rd_d = rd_q + ADDR_W'(qw_q);
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      chg_q     <= 1'b0;
      last_q    <= 1'b0;
      qw_q      <= '0;
      rd_q      <= '0;
      used_q    <= '0;
      idle_q    <= '0;
      wr_prev_q <= '0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      chg_q     <= chg_d;
      last_q    <= last_d;
      qw_q      <= qw_d;
      rd_q      <= rd_d;
      used_q    <= used_d;
      idle_q    <= idle_d;
      wr_prev_q <= commited_wr_address;
    end
  end

  assign trigger_tlp                    = trig_q;
  assign qwords_to_send                 = qw_q;
  assign change_huge_page               = chg_q;
  assign send_last_tlp_change_huge_page = last_q;
  assign issued_rd_address              = rd_q;

endmodule

// File: tb/tb_rx_tlp_trigger.sv
// Bench for rx_tlp_trigger. Three instances with different page sizes and
// timeouts are driven side by side; a transaction-level model of the
// outstanding request, ring pointer and page fill predicts every output on
// every cycle, and directed scenarios add literal expectations.
module tb_rx_tlp_trigger;

  localparam int NDUT  = 3;
  localparam int AMASK = 511;
  localparam int MQ    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] wr   [NDUT];
  logic       tack [NDUT];
  logic       pack [NDUT];
  logic       trig [NDUT];
  logic       chg  [NDUT];
  logic       last [NDUT];
  logic [4:0] qw   [NDUT];
  logic [8:0] iss  [NDUT];

  // model state: pending request 0 = none, 1 = TLP, 2 = page switch
  int m_iss [NDUT];
  int m_used[NDUT];
  int m_idle[NDUT];
  int m_prev[NDUT];
  int m_pend[NDUT];
  int m_qw  [NDUT];
  bit m_last[NDUT];
  int ack_mode[NDUT];   // 0 manual, 1 answer requests, 2 also spurious acks

  int ntests = 0;
  int nfail  = 0;
  int cnt;
  bit active;

  always #5 clk = ~clk;

  rx_tlp_trigger #(.ADDR_W(9), .MAX_QW(16), .PAGE_QW(40), .TIMEOUT(1024)) dut0 (
    .trn_clk(clk), .reset(rst), .commited_wr_address(wr[0]),
    .trigger_tlp(trig[0]), .trigger_tlp_ack(tack[0]), .qwords_to_send(qw[0]),
    .change_huge_page(chg[0]), .change_huge_page_ack(pack[0]),
    .send_last_tlp_change_huge_page(last[0]), .issued_rd_address(iss[0]));

  rx_tlp_trigger #(.ADDR_W(9), .MAX_QW(16), .PAGE_QW(32), .TIMEOUT(24)) dut1 (
    .trn_clk(clk), .reset(rst), .commited_wr_address(wr[1]),
    .trigger_tlp(trig[1]), .trigger_tlp_ack(tack[1]), .qwords_to_send(qw[1]),
    .change_huge_page(chg[1]), .change_huge_page_ack(pack[1]),
    .send_last_tlp_change_huge_page(last[1]), .issued_rd_address(iss[1]));

  rx_tlp_trigger #(.ADDR_W(9), .MAX_QW(16), .PAGE_QW(262144), .TIMEOUT(30)) dut2 (
    .trn_clk(clk), .reset(rst), .commited_wr_address(wr[2]),
    .trigger_tlp(trig[2]), .trigger_tlp_ack(tack[2]), .qwords_to_send(qw[2]),
    .change_huge_page(chg[2]), .change_huge_page_ack(pack[2]),
    .send_last_tlp_change_huge_page(last[2]), .issued_rd_address(iss[2]));

  function automatic int pq_of(int k);
    return (k == 0) ? 40 : (k == 1) ? 32 : 262144;
  endfunction

  function automatic int to_of(int k);
    return (k == 0) ? 1024 : (k == 1) ? 24 : 30;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of the model, applied with the inputs seen at the edge.
  function automatic void model_step(int k);
    int avail, n, room, nidle;
    if (rst) begin
      m_iss[k] = 0; m_used[k] = 0; m_idle[k] = 0; m_prev[k] = 0;
      m_pend[k] = 0; m_qw[k] = 0; m_last[k] = 0;
      return;
    end
    avail = (int'(wr[k]) - m_iss[k]) & AMASK;
    if (int'(wr[k]) != m_prev[k] || avail == 0 || tack[k] || pack[k]) nidle = 0;
    else nidle = (m_idle[k] >= to_of(k)) ? to_of(k) : m_idle[k] + 1;
    if (m_pend[k] == 0) begin
      room = pq_of(k) - m_used[k];
      n = (avail < MQ) ? avail : MQ;
      if (room == 0) begin
        m_pend[k] = 2; m_last[k] = 0;
      end else if (avail >= MQ || (avail > 0 && m_idle[k] == to_of(k))) begin
        if (n <= room) begin
          m_pend[k] = 1; m_qw[k] = n;
        end else begin
          m_pend[k] = 2; m_last[k] = 1; m_qw[k] = room;
        end
      end
    end else if (m_pend[k] == 1) begin
      if (tack[k]) begin
        m_iss[k] = (m_iss[k] + m_qw[k]) & AMASK;
        m_used[k] = m_used[k] + m_qw[k];
        m_pend[k] = 0;
      end
    end else begin
      if (pack[k]) begin
        if (m_last[k]) m_iss[k] = (m_iss[k] + m_qw[k]) & AMASK;
        m_used[k] = 0; m_pend[k] = 0; m_last[k] = 0;
      end
    end
    m_idle[k] = nidle;
    m_prev[k] = int'(wr[k]);
  endfunction

  task automatic compare(int k);
    chk($sformatf("d%0d trigger_tlp", k), trig[k], m_pend[k] == 1);
    chk($sformatf("d%0d change_huge_page", k), chg[k], m_pend[k] == 2);
    chk($sformatf("d%0d send_last", k), last[k], (m_pend[k] == 2) && m_last[k]);
    chk($sformatf("d%0d issued_rd_address", k), iss[k], m_iss[k]);
    if (m_pend[k] == 1 || (m_pend[k] == 2 && m_last[k]))
      chk($sformatf("d%0d qwords_to_send", k), qw[k], m_qw[k]);
  endtask

  // Advance one clock: model at the edge, compare at the falling edge,
  // then prepare acks for the next cycle.
  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) compare(k);
    for (int k = 0; k < NDUT; k++) begin
      tack[k] = 1'b0;
      pack[k] = 1'b0;
      if (ack_mode[k] != 0) begin
        tack[k] = trig[k] && ($urandom_range(0, 2) == 0);
        pack[k] = chg[k] && ($urandom_range(0, 2) == 0);
        if (ack_mode[k] == 2) begin
          if ($urandom_range(0, 15) == 0) tack[k] = 1'b1;
          if ($urandom_range(0, 15) == 0) pack[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      wr[k] = '0; tack[k] = 1'b0; pack[k] = 1'b0; ack_mode[k] = 0;
    end
    cyc();
    cyc();
    chk("reset trigger_tlp", trig[0], 0);
    chk("reset change_huge_page", chg[0], 0);
    chk("reset send_last", last[0], 0);
    chk("reset qwords_to_send", qw[0], 0);
    chk("reset issued", iss[0], 0);
    rst = 1'b0;

    // Full TLP
    wr[0] = 9'd16;
    cyc();
    chk("full trigger", trig[0], 1);
    chk("full qwords", qw[0], 16);
    tack[0] = 1'b1;
    cyc();
    chk("full issued after ack", iss[0], 16);
    chk("full trigger after ack", trig[0], 0);
    chk("model issued after full", m_iss[0], 16);

    // Timeout flush of 5 qwords: idle reaches 1024 after 1025 edges,
    // and the request registers on the following edge.
    wr[0] = 9'd21;
    cnt = 0;
    while (trig[0] !== 1'b1 && cnt < 1100) begin
      cyc();
      cnt++;
    end
    chk("timeout latency", cnt, 1026);
    chk("timeout qwords", qw[0], 5);
    tack[0] = 1'b1;
    cyc();
    chk("timeout issued", iss[0], 21);

    // Exact page fill on the 32-qword page instance
    wr[1] = 9'd16;
    cyc();
    chk("fill first trigger", trig[1], 1);
    tack[1] = 1'b1;
    cyc();
    wr[1] = 9'd32;
    cyc();
    chk("fill second trigger", trig[1], 1);
    tack[1] = 1'b1;
    cyc();
    chk("fill issued", iss[1], 32);
    cyc();
    chk("fill change_huge_page", chg[1], 1);
    chk("fill send_last", last[1], 0);
    chk("fill no trigger", trig[1], 0);
    pack[1] = 1'b1;
    cyc();
    chk("fill change after ack", chg[1], 0);
    chk("fill issued after page", iss[1], 32);

    // Page boundary on the 40-qword page instance
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) wr[k] = '0;
    cyc();
    rst = 1'b0;
    wr[0] = 9'd16;
    cyc();
    tack[0] = 1'b1;
    cyc();
    wr[0] = 9'd32;
    cyc();
    tack[0] = 1'b1;
    cyc();
    chk("model page_used 32", m_used[0], 32);
    wr[0] = 9'd48;
    cyc();
    chk("boundary change_huge_page", chg[0], 1);
    chk("boundary send_last", last[0], 1);
    chk("boundary qwords", qw[0], 8);
    chk("boundary no trigger", trig[0], 0);
    pack[0] = 1'b1;
    cyc();
    chk("boundary issued", iss[0], 40);
    chk("boundary change after ack", chg[0], 0);
    chk("model page_used cleared", m_used[0], 0);
    cnt = 0;
    while (trig[0] !== 1'b1 && chg[0] !== 1'b1 && cnt < 1100) begin
      cyc();
      cnt++;
    end
    chk("boundary next trigger", trig[0], 1);
    chk("boundary next qwords", qw[0], 8);
    tack[0] = 1'b1;
    cyc();
    chk("boundary final issued", iss[0], 48);

    // Pointer wrap on the default-page instance
    ack_mode[2] = 1;
    wr[2] = 9'd504;
    cnt = 0;
    while (iss[2] !== 9'd504 && cnt < 2000) begin
      cyc();
      cnt++;
    end
    chk("wrap reached 504", iss[2], 504);
    ack_mode[2] = 0;
    tack[2] = 1'b0;
    pack[2] = 1'b0;
    wr[2] = 9'd8;
    cyc();
    chk("wrap trigger", trig[2], 1);
    chk("wrap qwords", qw[2], 16);
    tack[2] = 1'b1;
    cyc();
    chk("wrap issued", iss[2], 8);

    // Reset while a TLP request waits for its ack
    wr[2] = 9'd24;
    cyc();
    chk("pre-reset trigger", trig[2], 1);
    cyc();
    chk("held trigger", trig[2], 1);
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) wr[k] = '0;
    cyc();
    chk("reset drops trigger", trig[2], 0);
    chk("reset qwords", qw[2], 0);
    chk("reset issued mid-wait", iss[2], 0);
    chk("reset change", chg[2], 0);
    rst = 1'b0;
    tack[2] = 1'b1;
    cyc();
    chk("late ack trigger", trig[2], 0);
    chk("late ack issued", iss[2], 0);

    // Randomized traffic, checked every cycle against the model
    for (int k = 0; k < NDUT; k++) ack_mode[k] = 2;
    active = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) active = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 999) == 0);
      if (active) begin
        for (int k = 0; k < NDUT; k++) begin
          int step;
          step = $urandom_range(0, 6);
          if ((((int'(wr[k]) - m_iss[k]) & AMASK) + step) <= 480) wr[k] = wr[k] + 9'(step);
        end
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
